// File: rtl/score_keeper.sv
// Scoring stage for the DDR game: turns per-arrow judgements into score, combo,
// max combo and multiplier, with the score clamped to what the 4-digit display can show.
module score_keeper #(
  parameter int PTS_PERFECT  = 30,
  parameter int PTS_GREAT    = 20,
  parameter int PTS_GOOD     = 10,
  parameter int MISS_PENALTY = 15,
  parameter int SCORE_MAX    = 9999,
  parameter int COMBO_STEP   = 10,
  parameter int MULT_MAX     = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_active,
  input  logic        i_judge_valid,
  input  logic [1:0]  i_judge,
  output logic [31:0] o_score,
  output logic [15:0] o_combo,
  output logic [15:0] o_max_combo,
  output logic [2:0]  o_mult,
  output logic        o_update
);

  localparam int SW = $clog2(SCORE_MAX + 1);
  localparam int CW = $clog2(COMBO_STEP + 1);

  logic [SW-1:0] score_q, score_d;
  logic [15:0]   combo_q, combo_d, max_q, max_d;
  logic [2:0]    mult_q, mult_d;
  logic [CW-1:0] step_q, step_d;
  logic [16:0]   base, sum;
  logic          accept;

  assign accept = i_judge_valid & i_active & ~i_start;

  // Points use the multiplier held before this hit; the sum is wide enough that
  // the clamp compares against the true total rather than a wrapped one.
  always_comb begin
    score_d = score_q;
    combo_d = combo_q;
    max_d   = max_q;
    mult_d  = mult_q;
    step_d  = step_q;
    base    = '0;
    sum     = '0;
    case (i_judge)
      2'b01:   base = 17'(PTS_GOOD);
      2'b10:   base = 17'(PTS_GREAT);
      2'b11:   base = 17'(PTS_PERFECT);
      default: base = '0;
    endcase
    if (i_judge == 2'b00) begin
      score_d = (score_q < SW'(MISS_PENALTY)) ? '0 : score_q - SW'(MISS_PENALTY);
      combo_d = '0;
      step_d  = '0;
      mult_d  = 3'd1;
    end else begin
      sum     = 17'(score_q) + base * 17'(mult_q);
      score_d = (sum > 17'(SCORE_MAX)) ? SW'(SCORE_MAX) : sum[SW-1:0];
      combo_d = (combo_q == 16'hFFFF) ? combo_q : combo_q + 16'd1;
      max_d   = (combo_d > max_q) ? combo_d : max_q;
      if (step_q + CW'(1) == CW'(COMBO_STEP)) begin
        step_d = '0;
        mult_d = (mult_q >= 3'(MULT_MAX)) ? 3'(MULT_MAX) : mult_q + 3'd1;
      end else begin
        step_d = step_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      score_q  <= '0;
      combo_q  <= '0;
      max_q    <= '0;
      mult_q   <= 3'd1;
      step_q   <= '0;
      o_update <= 1'b0;
    end else if (i_start) begin
      score_q  <= '0;
      combo_q  <= '0;
      max_q    <= '0;
      mult_q   <= 3'd1;
      step_q   <= '0;
      o_update <= 1'b0;
    end else if (accept) begin
      score_q  <= score_d;
      combo_q  <= combo_d;
      max_q    <= max_d;
      mult_q   <= mult_d;
      step_q   <= step_d;
      o_update <= 1'b1;
    end else begin
      o_update <= 1'b0;
    end
  end

  assign o_score     = 32'(score_q);
  assign o_combo     = combo_q;
  assign o_max_combo = max_q;
  assign o_mult      = mult_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: hand-computed score, combo and multiplier
// sequences covering reset, multiplier stepping, miss floor, saturation and start priority.
module tb_score_keeper;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_active = 1'b0;
  logic        i_judge_valid = 1'b0;
  logic [1:0]  i_judge = 2'b00;
  logic [31:0] o_score;
  logic [15:0] o_combo;
  logic [15:0] o_max_combo;
  logic [2:0]  o_mult;
  logic        o_update;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] MISS    = 2'b00;
  localparam logic [1:0] GOOD    = 2'b01;
  localparam logic [1:0] GREAT   = 2'b10;
  localparam logic [1:0] PERFECT = 2'b11;

  always #5 i_clk = ~i_clk;

  score_keeper dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_active(i_active),
    .i_judge_valid(i_judge_valid),
    .i_judge(i_judge),
    .o_score(o_score),
    .o_combo(o_combo),
    .o_max_combo(o_max_combo),
    .o_mult(o_mult),
    .o_update(o_update)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int score, input int combo, input int max_combo,
                          input int mult, input int update);
    checkOutput({tag, ".score"}, o_score, 32'(score));
    checkOutput({tag, ".combo"}, 32'(o_combo), 32'(combo));
    checkOutput({tag, ".max_combo"}, 32'(o_max_combo), 32'(max_combo));
    checkOutput({tag, ".mult"}, 32'(o_mult), 32'(mult));
    checkOutput({tag, ".update"}, 32'(o_update), 32'(update));
  endtask

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic valid, input logic [1:0] judge, input logic start);
    i_judge_valid = valid;
    i_judge       = judge;
    i_start       = start;
    @(posedge i_clk);
    #1;
    i_judge_valid = 1'b0;
    i_start       = 1'b0;
  endtask

  initial begin
    #12;
    checkAll("por", 0, 0, 0, 1, 0);
    @(negedge i_clk);
    i_rst_n  = 1'b1;
    i_active = 1'b1;

    applyStimulus(1'b0, MISS, 1'b1);
    checkAll("start", 0, 0, 0, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, PERFECT, 1'b0);
      checkAll("perfect_chain", 30 * k, k, k, 1, 1);
    end
    applyStimulus(1'b0, MISS, 1'b0);
    checkAll("idle", 90, 3, 3, 1, 0);
    i_active = 1'b0;
    applyStimulus(1'b1, PERFECT, 1'b0);
    checkAll("inactive", 90, 3, 3, 1, 0);
    i_active = 1'b1;

    applyStimulus(1'b0, MISS, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(1'b1, GREAT, 1'b0);
      checkAll("mult_step", (k <= 10) ? 20 * k : 200 + 40 * (k - 10), k, k, (k >= 10) ? 2 : 1, 1);
    end

    #2 i_rst_n = 1'b0;
    #1 checkAll("async_rst", 0, 0, 0, 1, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    applyStimulus(1'b0, MISS, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b1, GREAT, 1'b0);
      checkOutput("mult_hold", 32'(o_mult), (k >= 30) ? 32'd4 : 32'(1 + k / 10));
    end
    checkAll("mult_end", 2000, 40, 40, 4, 1);

    applyStimulus(1'b0, MISS, 1'b1);
    applyStimulus(1'b1, GOOD, 1'b0);
    checkAll("good_one", 10, 1, 1, 1, 1);
    applyStimulus(1'b1, MISS, 1'b0);
    checkAll("miss_floor", 0, 0, 1, 1, 1);
    applyStimulus(1'b1, MISS, 1'b0);
    checkAll("miss_at_zero", 0, 0, 1, 1, 1);
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, GOOD, 1'b0);
    checkAll("combo5", 50, 5, 5, 1, 1);
    applyStimulus(1'b1, MISS, 1'b0);
    checkAll("miss_keep_max", 35, 0, 5, 1, 1);

    applyStimulus(1'b0, MISS, 1'b1);
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, GREAT, 1'b0);
    checkOutput("score100", o_score, 32'd100);
    applyStimulus(1'b1, MISS, 1'b0);
    checkAll("miss_100", 85, 0, 5, 1, 1);

    applyStimulus(1'b0, MISS, 1'b1);
    for (int k = 1; k <= 9; k++) applyStimulus(1'b1, GOOD, 1'b0);
    applyStimulus(1'b1, MISS, 1'b0);
    checkAll("miss_step", 75, 0, 9, 1, 1);
    applyStimulus(1'b1, GOOD, 1'b0);
    checkAll("step_cleared", 85, 1, 9, 1, 1);
    for (int k = 1; k <= 9; k++) applyStimulus(1'b1, GOOD, 1'b0);
    checkAll("step_restart", 175, 10, 10, 2, 1);

    applyStimulus(1'b0, MISS, 1'b1);
    for (int k = 1; k <= 30; k++) applyStimulus(1'b1, GREAT, 1'b0);
    checkAll("sat_setup", 1200, 30, 30, 4, 1);
    for (int k = 1; k <= 73; k++) applyStimulus(1'b1, PERFECT, 1'b0);
    checkAll("sat_below", 9960, 103, 103, 4, 1);
    applyStimulus(1'b1, PERFECT, 1'b0);
    checkAll("sat_cross", 9999, 104, 104, 4, 1);
    applyStimulus(1'b1, PERFECT, 1'b0);
    checkAll("sat_hold", 9999, 105, 105, 4, 1);
    checkOutput("upper_zero", 32'(o_score[31:14]), 32'd0);
    applyStimulus(1'b1, MISS, 1'b0);
    checkAll("sat_miss", 9984, 0, 105, 1, 1);

    applyStimulus(1'b1, PERFECT, 1'b1);
    checkAll("start_prio", 0, 0, 0, 1, 0);
    applyStimulus(1'b0, MISS, 1'b0);
    checkAll("start_after", 0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
